// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> multiply/divide controller bundle: op request, HI/LO moves, stall/completion.
// Latency: none, this is wiring only.
// Backpressure: busy_o stalls the execute stage; valid_i/a_i/b_i are held stable while busy_o=1.
interface muldiv_ctrl_if;
    logic        valid_i;
    logic [3:0]  funct_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        hi_we_i;
    logic        lo_we_i;
    logic [31:0] wdata_i;
    logic        flush_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    // execute stage side
    modport master (
        output valid_i, funct_i, a_i, b_i, hi_we_i, lo_we_i, wdata_i, flush_i,
        input  busy_o, done_o, hi_o, lo_o
    );

    // controller side
    modport slave (
        input  valid_i, funct_i, a_i, b_i, hi_we_i, lo_we_i, wdata_i, flush_i,
        output busy_o, done_o, hi_o, lo_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle mult/multu/div/divu sequencer owning architectural HI/LO; MULDIV_MADD_EN adds madd/maddu.
// Latency: multiply MUL_LAT+1 cycles to done_o, divide 34 cycles (32 DIV + FIX + DONE).
// Backpressure: busy_o stalls the pipe while in flight; done_o pulses one cycle; flush_i aborts with no HI/LO write.
module muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_ctrl_if.slave bus
);
    localparam logic [3:0] F_MULT  = 4'b1011;
    localparam logic [3:0] F_MULTU = 4'b1100;
    localparam logic [3:0] F_DIV   = 4'b1101;
    localparam logic [3:0] F_DIVU  = 4'b1110;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] F_MADD  = 4'b1001;
    localparam logic [3:0] F_MADDU = 4'b1010;
`endif
    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  cnt;
    logic [31:0] a_q, b_q;      // raw operands, kept for sign fix and div-by-zero result
    logic        sgn_q;         // signed variant of the op
`ifdef MULDIV_MADD_EN
    logic        acc_q;         // accumulate into {HI,LO}
`endif
    logic [31:0] hi_q, lo_q;
    logic [31:0] rem_q;         // partial remainder
    logic [31:0] quo_q;         // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] dvs_q;         // divisor magnitude

    logic        is_mul, is_div, is_sgn, is_acc;
    logic        start;
    logic        busy, done;
    logic [63:0] a_ext, b_ext, prod, mul_res;
    logic [32:0] rem_sh, rem_sub;
    logic        q_bit;
    logic [31:0] rem_nxt;
    logic [31:0] quo_fix, rem_fix;
    logic [31:0] mag_a, mag_b;

    // Decode funct into op class; unlisted codes fall through as no-ops.
    always_comb begin
        is_mul = 1'b0;
        is_div = 1'b0;
        is_sgn = 1'b0;
        is_acc = 1'b0;
        case (bus.funct_i)
            F_MULT:  begin is_mul = 1'b1; is_sgn = 1'b1; end
            F_MULTU: begin is_mul = 1'b1; end
            F_DIV:   begin is_div = 1'b1; is_sgn = 1'b1; end
            F_DIVU:  begin is_div = 1'b1; end
`ifdef MULDIV_MADD_EN
            F_MADD:  begin is_mul = 1'b1; is_sgn = 1'b1; is_acc = 1'b1; end
            F_MADDU: begin is_mul = 1'b1; is_acc = 1'b1; end
`endif
            default: ;
        endcase
    end

    assign start = (state == IDLE) && bus.valid_i && (is_mul || is_div) && !bus.flush_i;
    assign mag_a = (is_sgn && bus.a_i[31]) ? -bus.a_i : bus.a_i;
    assign mag_b = (is_sgn && bus.b_i[31]) ? -bus.b_i : bus.b_i;

    // Product and (optional) accumulate result for the final MUL cycle.
    always_comb begin
        a_ext   = {(sgn_q ? {32{a_q[31]}} : 32'h0), a_q};
        b_ext   = {(sgn_q ? {32{b_q[31]}} : 32'h0), b_q};
        prod    = a_ext * b_ext;
`ifdef MULDIV_MADD_EN
        mul_res = acc_q ? ({hi_q, lo_q} + prod) : prod;
`else
        mul_res = prod;
`endif
    end

    // One restoring shift-subtract step, plus the sign fix applied in FIX.
    always_comb begin
        rem_sh  = {rem_q, quo_q[31]};
        rem_sub = rem_sh - {1'b0, dvs_q};
        q_bit   = (rem_sh >= {1'b0, dvs_q});
        rem_nxt = q_bit ? rem_sub[31:0] : rem_sh[31:0];
        quo_fix = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
        rem_fix = (sgn_q && a_q[31]) ? -rem_q : rem_q;
    end

    // Next-state and stall/completion outputs; flush wins over every transition.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = bus.valid_i && (is_mul || is_div);
                if (start) state_nxt = is_mul ? MUL : DIV;
            end
            MUL: begin
                busy = 1'b1;
                if (bus.flush_i)          state_nxt = IDLE;
                else if (cnt == MUL_LAST) state_nxt = DONE;
            end
            DIV: begin
                busy = 1'b1;
                if (bus.flush_i)          state_nxt = IDLE;
                else if (cnt == DIV_LAST) state_nxt = FIX;
            end
            FIX: begin
                busy = 1'b1;
                state_nxt = bus.flush_i ? IDLE : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Operand capture, iteration counter, divider datapath and HI/LO commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
`ifdef MULDIV_MADD_EN
            acc_q <= 1'b0;
`endif
            hi_q  <= '0;
            lo_q  <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // mthi/mtlo land now even if an op starts; the op result overwrites later
                    if (bus.hi_we_i) hi_q <= bus.wdata_i;
                    if (bus.lo_we_i) lo_q <= bus.wdata_i;
                    if (start) begin
                        cnt   <= '0;
                        a_q   <= bus.a_i;
                        b_q   <= bus.b_i;
                        sgn_q <= is_sgn;
`ifdef MULDIV_MADD_EN
                        acc_q <= is_acc;
`endif
                        rem_q <= '0;
                        quo_q <= mag_a;
                        dvs_q <= mag_b;
                    end
                end
                MUL: begin
                    if (!bus.flush_i) begin
                        if (cnt == MUL_LAST) begin
                            hi_q <= mul_res[63:32];
                            lo_q <= mul_res[31:0];
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                DIV: begin
                    if (!bus.flush_i) begin
                        rem_q <= rem_nxt;
                        quo_q <= {quo_q[30:0], q_bit};
                        cnt   <= cnt + 6'd1;
                    end
                end
                FIX: begin
                    if (!bus.flush_i) begin
                        if (b_q == 32'h0) begin
                            // divide by zero: all-ones quotient, dividend as remainder
                            lo_q <= 32'hFFFF_FFFF;
                            hi_q <= a_q;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o = busy;
    assign bus.done_o = done;
    assign bus.hi_o   = hi_q;
    assign bus.lo_o   = lo_q;

    // is_acc only feeds the accumulate flag when madd is built in
    logic unused_ok;
    assign unused_ok = is_acc;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: directed ops push expected HI/LO and done cycle, a monitor checks on done_o.
// Latency: expects done_o at T+3 for multiply (MUL_LAT=2) and T+34 for divide.
// Backpressure: valid_i held until done_o, then dropped so the op does not restart.
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_ctrl_if bus();

    muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done_o must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done_o=1 at cycle %0d with no op outstanding", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, " hi"}, bus.hi_o, e.hi);
                check({e.name, " lo"}, bus.lo_o, e.lo);
                check({e.name, " done_cycle"}, cyc, e.cyc);
            end
        end
    end

    task automatic start_op(input string nm, input logic [3:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                            input int lat);
        exp_t e;
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.funct_i = f;
        bus.a_i     = a;
        bus.b_i     = b;
        e.hi = ehi; e.lo = elo; e.cyc = cyc + lat; e.name = nm;
        sb.push_back(e);
        #1;
        check({nm, " busy_at_start"}, bus.busy_o, 1);
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no done_o within 60 cycles", nm);
        end else begin
            check({nm, " busy_in_done"}, bus.busy_o, 0);
        end
        bus.valid_i = 1'b0;
        @(negedge clk);
        check({nm, " done_one_cycle"}, bus.done_o, 0);
    endtask

    task automatic run_op(input string nm, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat);
        start_op(nm, f, a, b, ehi, elo, lat);
        wait_done(nm);
    endtask

    task automatic write_hilo(input logic hwe, input logic lwe, input logic [31:0] d);
        @(negedge clk);
        bus.hi_we_i = hwe;
        bus.lo_we_i = lwe;
        bus.wdata_i = d;
        @(negedge clk);
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
    endtask

    // Flush an in-flight divu 100/3 after 'after' cycles past the sampling cycle.
    task automatic flush_at(input string nm, input int after);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.funct_i = 4'b1110;
        bus.a_i     = 32'd100;
        bus.b_i     = 32'd3;
        repeat (after) @(negedge clk);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        check({nm, " idle_after_flush"}, bus.busy_o, 0);
        repeat (40) @(negedge clk);
        check({nm, " hi_kept"}, bus.hi_o, 32'd5);
        check({nm, " lo_kept"}, bus.lo_o, 32'd6);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.valid_i = 1'b0;
        bus.funct_i = 4'h0;
        bus.a_i     = '0;
        bus.b_i     = '0;
        bus.hi_we_i = 1'b0;
        bus.lo_we_i = 1'b0;
        bus.wdata_i = '0;
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", bus.hi_o, 0);
        check("reset lo", bus.lo_o, 0);
        check("reset busy", bus.busy_o, 0);
        check("reset done", bus.done_o, 0);
        reset = 1'b0;

        // mthi in IDLE shows up the next cycle
        write_hilo(1'b1, 1'b0, 32'hA5A5_A5A5);
        check("mthi hi", bus.hi_o, 32'hA5A5_A5A5);
        check("mthi lo_untouched", bus.lo_o, 0);

        // multiplies: done at T+3
        run_op("mult_m1x2",  4'b1011, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
        run_op("multu_m1x2", 4'b1100, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 3);
        run_op("mult_3xm5",  4'b1011, 32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 3);

        // divides: done at T+34
        run_op("div_m7d2",   4'b1101, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
        run_op("div_7dm2",   4'b1101, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34);
        run_op("divu_7d0",   4'b1110, 32'd7,         32'd0,         32'h0000_0007, 32'hFFFF_FFFF, 34);
        run_op("div_m9d0",   4'b1101, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 34);
        run_op("div_min_m1", 4'b1101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34);

        // mtlo during DIV is ignored
        start_op("divu_100d3", 4'b1110, 32'd100, 32'd3, 32'd1, 32'd33, 34);
        repeat (5) @(negedge clk);
        bus.lo_we_i = 1'b1;
        bus.wdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.lo_we_i = 1'b0;
        check("mtlo_in_div lo", bus.lo_o, 32'h8000_0000);
        wait_done("divu_100d3");

        // flush mid-DIV and in FIX: no done, HI/LO keep preset
        write_hilo(1'b1, 1'b0, 32'd5);
        write_hilo(1'b0, 1'b1, 32'd6);
        flush_at("flush_div", 20);
        flush_at("flush_fix", 33);

        // madd/maddu only with MULDIV_MADD_EN
        write_hilo(1'b1, 1'b0, 32'h0);
        write_hilo(1'b0, 1'b1, 32'hFFFF_FFFF);
`ifdef MULDIV_MADD_EN
        run_op("maddu_1x1", 4'b1010, 32'd1, 32'd1, 32'h0000_0001, 32'h0000_0000, 3);
`else
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.funct_i = 4'b1010;
        bus.a_i     = 32'd1;
        bus.b_i     = 32'd1;
        #1;
        check("maddu_noop busy", bus.busy_o, 0);
        repeat (6) @(negedge clk);
        bus.valid_i = 1'b0;
        check("maddu_noop hi", bus.hi_o, 32'h0);
        check("maddu_noop lo", bus.lo_o, 32'hFFFF_FFFF);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide controller for the execute stage. It accepts HI/LO-class instructions, sequences a fixed-latency multiplier and a radix-2 iterative divider, and owns the architectural HI/LO registers. While an operation is in flight it stalls the pipeline, and it signals completion with a one-cycle `done_o`.

## Interface
- `MUL_LAT`, default 2: multiply latency in cycles spent in MUL state (1..4).
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `valid_i` in 1: execute-stage instruction valid; held stable while `busy_o`=1.
- `funct_i` in 4: 4'b1011 mult, 4'b1100 multu, 4'b1101 div, 4'b1110 divu; other codes are no-ops.
- `a_i`, `b_i` in 32 each: operands (rs, rt), stable while `busy_o`=1.
- `hi_we_i`, `lo_we_i` in 1 each: mthi/mtlo write enables.
- `wdata_i` in 32: mthi/mtlo data.
- `flush_i` in 1: abort the in-flight operation.
- `busy_o` out 1: stall request.
- `done_o` out 1: result committed this cycle; execute stage advances.
- `hi_o`, `lo_o` out 32 each: architectural HI/LO, registered.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. Reset state is IDLE.
- Reset values: `hi_o`=`lo_o`=0, `busy_o`=0, `done_o`=0, counter=0.
- IDLE
  - `valid_i` with a recognised funct latches the operands.
  - Multiply goes to MUL; divide goes to DIV.
  - `busy_o` = `valid_i` & recognised funct, combinationally.
- MUL
  - Full 64-bit product: signed uses sign extension, unsigned uses zero extension.
  - Counts `MUL_LAT` cycles, writes HI=product[63:32] and LO=product[31:0] at the end of the last cycle, then goes to DONE.
- DIV
  - Restoring shift-subtract on operand magnitudes, 32 cycles, one quotient bit per cycle, 6-bit counter.
  - Goes to FIX afterwards.
- FIX (signed div only)
  - Quotient is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Writes LO=quotient, HI=remainder, then goes to DONE.
- Divide by zero: LO=32'hFFFF_FFFF, HI=dividend, for both signed and unsigned. No exception.
- INT_MIN / -1 (signed): LO=32'h8000_0000, HI=0.
- DONE
  - `done_o`=1 and `busy_o`=0 for exactly one cycle, then IDLE.
  - `valid_i` is ignored in DONE, so the completing instruction does not restart.
- mthi/mtlo writes are honoured only in IDLE and ignored elsewhere. If a write and an op start coincide in IDLE, the write happens now and the op result overwrites HI/LO later.
- `flush_i` has the highest priority: any non-IDLE state goes to IDLE next cycle with no HI/LO write. In IDLE, flush suppresses the start.
- `busy_o`=1 in MUL, DIV and FIX.

## Timing
- T = the IDLE cycle in which the op is sampled.
- Multiply:
  - MUL occupies T+1 .. T+`MUL_LAT`.
  - DONE is at T+`MUL_LAT`+1; HI/LO are visible that cycle.
- Divide:
  - DIV occupies T+1 .. T+32.
  - FIX is at T+33; DONE is at T+34; HI/LO are visible from T+34.
  - The sign fix runs for divu as well, as a pass-through, so latency is fixed.
- Back-to-back: the next op can be sampled at the earliest in the cycle after DONE.
- Flush during FIX: HI/LO keep their pre-op values.

## Configuration
- `MULDIV_MADD_EN` defined:
  - Adds funct 4'b1001 madd and 4'b1010 maddu, with the same timing as mult/multu.
  - The MUL final cycle writes {HI,LO} + product, modulo 2^64.
- Not defined: 4'b1001 and 4'b1010 are no-ops (no busy, no write).

## Test plan
- mult a=32'hFFFF_FFFF, b=2 -> DONE at T+3 (`MUL_LAT`=2), HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE. multu with the same operands -> HI=1, LO=32'hFFFF_FFFE.
- div a=-7, b=2 -> `done_o` at T+34, LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. divu a=7, b=0 -> LO=32'hFFFF_FFFF, HI=7.
- div a=32'h8000_0000, b=32'hFFFF_FFFF -> LO=32'h8000_0000, HI=0.
- Flush at T+20 of divu 100/3 with HI/LO preset to 5/6 -> IDLE at T+21, no `done_o`, HI=5, LO=6.
- mthi 32'hA5A5_A5A5 in IDLE -> HI updated next cycle. mtlo asserted while in DIV -> ignored.
- `MULDIV_MADD_EN`: HI=0, LO=32'hFFFF_FFFF, maddu 1*1 -> HI=1, LO=0. Without the macro the same stimulus gives `busy_o`=0 and HI/LO unchanged.
